// File: rtl/traffic_monitor.sv
// Lamp-side conflict monitor: decodes windowed R/G/B lamp drives into per-direction
// light states and raises sticky fault flags on illegal signalling.
module traffic_monitor #(
    parameter int unsigned CLK_PER    = 10,
    parameter int unsigned WIN        = 4,
    parameter int unsigned YELLOW_MIN = 1000000000 / CLK_PER
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] R,
    input  logic [1:0] G,
    input  logic [1:0] B,
    input  logic       fault_clr,
    output logic [1:0] ud_state,
    output logic [1:0] lr_state,
    output logic       state_valid,
    output logic [3:0] fault_code,
    output logic       fault
);

    localparam int unsigned CW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int unsigned YW = $clog2(YELLOW_MIN + WIN);

    localparam logic [1:0] ST_RED    = 2'd0;
    localparam logic [1:0] ST_YELLOW = 2'd1;
    localparam logic [1:0] ST_GREEN  = 2'd2;
    localparam logic [1:0] ST_DARK   = 2'd3;

    function automatic logic [1:0] decode(input logic r, input logic g);
        logic [1:0] st;
        case ({r, g})
            2'b10:   st = ST_RED;
            2'b11:   st = ST_YELLOW;
            2'b01:   st = ST_GREEN;
            default: st = ST_DARK;
        endcase
        return st;
    endfunction

    // Hold is always legal; only the R->G->Y->R ring is allowed otherwise.
    function automatic logic legal_step(input logic [1:0] p, input logic [1:0] n);
        return (p == n) ||
               (p == ST_RED    && n == ST_GREEN)  ||
               (p == ST_GREEN  && n == ST_YELLOW) ||
               (p == ST_YELLOW && n == ST_RED);
    endfunction

    logic [CW-1:0]        cnt;
    logic [1:0]           acc_r, acc_g, acc_b;
    logic                 armed;
    logic [1:0][YW-1:0]   ycnt;

    logic                 last;
    logic [1:0]           win_r, win_g, win_b;
    logic [1:0][1:0]      dec;
    logic [1:0][1:0]      prev;
    logic                 b_seen;
    logic                 arm_now;
    logic [3:0]           det;
    logic [1:0][YW-1:0]   ynext;
    logic [YW:0]          ysum;

    // Window decode, rule checks and yellow-counter update.
    always_comb begin
        last    = (cnt == CW'(WIN - 1));
        win_r   = acc_r | R;
        win_g   = acc_g | G;
        win_b   = acc_b | B;
        b_seen  = |win_b;
        dec[0]  = decode(win_r[0], win_g[0]);
        dec[1]  = decode(win_r[1], win_g[1]);
        prev[0] = lr_state;
        prev[1] = ud_state;
        det     = '0;
        ynext   = ycnt;
        ysum    = '0;
        for (int d = 0; d < 2; d++) begin
            if (!legal_step(prev[d], dec[d])) det[1] = 1'b1;
            if (prev[d] == ST_YELLOW && dec[d] == ST_RED && ycnt[d] < YW'(YELLOW_MIN))
                det[2] = 1'b1;
            if (dec[d] == ST_DARK) det[3] = 1'b1;
            ysum = (YW+1)'(ycnt[d]) + (YW+1)'(WIN);
            if (dec[d] != ST_YELLOW)
                ynext[d] = '0;
            else if (ysum >= (YW+1)'(YELLOW_MIN))
                ynext[d] = YW'(YELLOW_MIN);
            else
                ynext[d] = YW'(ysum);
        end
        if (b_seen) det[3] = 1'b1;
        if ((dec[0] == ST_YELLOW || dec[0] == ST_GREEN) &&
            (dec[1] == ST_YELLOW || dec[1] == ST_GREEN))
            det[0] = 1'b1;
        if (!(last && armed)) det = '0;
        arm_now = !armed && last && dec[0] != ST_DARK && dec[1] != ST_DARK && !b_seen;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            acc_r       <= '0;
            acc_g       <= '0;
            acc_b       <= '0;
            armed       <= 1'b0;
            ycnt        <= '0;
            ud_state    <= ST_DARK;
            lr_state    <= ST_DARK;
            state_valid <= 1'b0;
            fault_code  <= '0;
            fault       <= 1'b0;
        end else begin
            state_valid <= last;
            // Clear wins over old bits only; a same-cycle detection survives it.
            fault_code  <= (fault_clr ? 4'b0000 : fault_code) | det;
            fault       <= |fault_code;
            if (arm_now) armed <= 1'b1;
            if (last) begin
                cnt      <= '0;
                acc_r    <= '0;
                acc_g    <= '0;
                acc_b    <= '0;
                ycnt     <= ynext;
                ud_state <= dec[1];
                lr_state <= dec[0];
            end else begin
                cnt   <= cnt + CW'(1);
                acc_r <= win_r;
                acc_g <= win_g;
                acc_b <= win_b;
            end
        end
    end

endmodule

// File: tb/tb_traffic_monitor.sv
// Scoreboard bench for traffic_monitor: stimulus pushes expected per-window decodes,
// a negedge monitor pops and compares on each state_valid.
module tb_traffic_monitor;

    localparam int unsigned WIN  = 4;
    localparam int unsigned YMIN = 16;

    localparam logic [1:0] RD = 2'd0;
    localparam logic [1:0] YL = 2'd1;
    localparam logic [1:0] GR = 2'd2;
    localparam logic [1:0] DK = 2'd3;

    logic       clk;
    logic       rst_n;
    logic [1:0] R, G, B;
    logic       fault_clr;
    logic [1:0] ud_state, lr_state;
    logic       state_valid;
    logic [3:0] fault_code;
    logic       fault;

    int n_cmp = 0;
    int n_bad = 0;
    int ph    = 0;

    logic [7:0] exp_q[$];

    traffic_monitor #(.CLK_PER(10), .WIN(WIN), .YELLOW_MIN(YMIN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .R          (R),
        .G          (G),
        .B          (B),
        .fault_clr  (fault_clr),
        .ud_state   (ud_state),
        .lr_state   (lr_state),
        .state_valid(state_valid),
        .fault_code (fault_code),
        .fault      (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] lamp(input logic [1:0] st);
        case (st)
            RD:      return 2'b10;
            YL:      return 2'b11;
            GR:      return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic drive(input logic [1:0] ud, input logic [1:0] lr, input logic bl,
                         input logic clr, input logic lit);
        logic [1:0] lu, ll;
        lu = lamp(ud);
        ll = lamp(lr);
        R = {lu[1] & lit, ll[1] & lit};
        G = {lu[0] & lit, ll[0] & lit};
        B = {1'b0, bl & lit};
        fault_clr = clr;
    endtask

    // One full window at 50% PWM; alternating phase covers both accumulator and live-sample paths.
    task automatic win(input logic [1:0] ud, input logic [1:0] lr, input logic bl,
                       input int clr_cyc, input logic [3:0] efc);
        exp_q.push_back({ud, lr, efc});
        for (int i = 0; i < int'(WIN); i++) begin
            drive(ud, lr, bl, (i == clr_cyc), ((i % 2) == ph));
            @(posedge clk);
            #1;
        end
        drive(DK, DK, 1'b0, 1'b0, 1'b0);
        ph = 1 - ph;
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_ud"},    32'(ud_state),    32'd3);
        check({nm, "_lr"},    32'(lr_state),    32'd3);
        check({nm, "_valid"}, 32'(state_valid), 32'd0);
        check({nm, "_fc"},    32'(fault_code),  32'd0);
        check({nm, "_fault"}, 32'(fault),       32'd0);
    endtask

    // Monitor: decode scoreboard, state_valid spacing, fault-follows-fault_code.
    int         gap = 0;
    logic       first = 1'b1;
    logic       prev_ok = 1'b0;
    logic [3:0] fc_prev = '0;
    logic [7:0] exp_item;
    int         n_dec = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            gap     = 0;
            first   = 1'b1;
            prev_ok = 1'b0;
        end else begin
            if (prev_ok) check("fault_follows", 32'(fault), 32'(|fc_prev));
            fc_prev = fault_code;
            prev_ok = 1'b1;
            gap++;
            if (state_valid) begin
                check("valid_spacing", 32'(gap), first ? WIN + 1 : WIN);
                gap   = 0;
                first = 1'b0;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got ud=%0d lr=%0d fc=%b with no expected entry",
                             ud_state, lr_state, fault_code);
                end else begin
                    exp_item = exp_q.pop_front();
                    n_dec++;
                    check($sformatf("decode%0d", n_dec),
                          32'({ud_state, lr_state, fault_code}), 32'(exp_item));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(DK, DK, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Unarmed dark window, then arming decode.
        win(DK, DK, 1'b0, -1, 4'b0000);
        win(GR, RD, 1'b0, -1, 4'b0000);

        // Legal full cycle.
        repeat (4) win(GR, RD, 1'b0, -1, 4'b0000);
        repeat (4) win(YL, RD, 1'b0, -1, 4'b0000);
        repeat (5) win(RD, GR, 1'b0, -1, 4'b0000);
        repeat (4) win(RD, YL, 1'b0, -1, 4'b0000);
        win(GR, RD, 1'b0, -1, 4'b0000);

        // Conflict, sticky through a legal return, then clear alone.
        win(GR, GR, 1'b0, -1, 4'b0001);
        repeat (4) win(GR, YL, 1'b0, -1, 4'b0001);
        win(GR, RD, 1'b0, -1, 4'b0001);
        win(GR, RD, 1'b0,  1, 4'b0000);

        // Green straight to red.
        win(RD, RD, 1'b0, -1, 4'b0010);
        win(RD, RD, 1'b0,  1, 4'b0000);

        // Yellow 12 clk < 16: short.
        win(GR, RD, 1'b0, -1, 4'b0000);
        repeat (3) win(YL, RD, 1'b0, -1, 4'b0000);
        win(RD, RD, 1'b0, -1, 4'b0100);
        win(RD, RD, 1'b0,  1, 4'b0000);

        // Yellow exactly 16: legal.
        win(GR, RD, 1'b0, -1, 4'b0000);
        repeat (4) win(YL, RD, 1'b0, -1, 4'b0000);
        win(RD, RD, 1'b0, -1, 4'b0000);

        // Blue lamp, clear alone, blue again, then clear colliding with a conflict decode.
        win(RD, RD, 1'b1, -1, 4'b1000);
        win(RD, RD, 1'b0,  1, 4'b0000);
        win(RD, RD, 1'b1, -1, 4'b1000);
        win(GR, GR, 1'b0,  3, 4'b0001);
        win(GR, GR, 1'b0, -1, 4'b0001);

        // Reset asserted at window cycle 2 with a fault pending.
        drive(GR, GR, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        drive(GR, GR, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        drive(DK, DK, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ph = 0;

        // Restart: unarmed again, re-arm, then faults resume including DARK lamp.
        win(DK, DK, 1'b0, -1, 4'b0000);
        win(GR, RD, 1'b0, -1, 4'b0000);
        win(RD, RD, 1'b0, -1, 4'b0010);
        win(DK, RD, 1'b0,  1, 4'b1010);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
